hilo_div_unit: RTL and testbench

Iterative 32-bit signed/unsigned divider: the producer side of the HI/LO path. It accepts DIV/DIVU operands from EXE, holds the pipeline stalled while it iterates, then presents one 64-bit HI/LO result with a 2-bit write mask. That result travels down the pipeline on the same hilo/whilo lanes the EXE-stage HI/LO forwarding logic reads from MEM and WB. Remainder goes to HI and quotient goes to LO.

---
 rtl/hilo_div_unit_pkg.sv | 25 ++
 rtl/hilo_div_unit_if.sv | 25 ++
 rtl/hilo_div_unit_div_step.sv | 24 ++
 rtl/hilo_div_unit.sv | 119 +++++++++++
 tb/tb_hilo_div_unit.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/hilo_div_unit_pkg.sv
// Shared widths, state encoding and HI/LO write-mask constants for the
// divider and the HI/LO forwarding/writeback path.
package hilo_div_unit_pkg;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned DWORD_W = 2 * WORD_W;
  localparam int unsigned PR_W    = DWORD_W + 1;
  localparam int unsigned DIV_ITER = WORD_W;

  typedef enum logic [1:0] {
    DIV_IDLE  = 2'd0,
    DIV_BUSY  = 2'd1,
    DIV_DZERO = 2'd2,
    DIV_DONE  = 2'd3
  } div_state_e;

  localparam logic [1:0] WHILO_NONE = 2'b00;
  localparam logic [1:0] WHILO_BOTH = 2'b11;

  // Two's-complement magnitude when neg is set; 0x8000_0000 maps to 2^31.
  function automatic logic [WORD_W-1:0] abs_if(input logic neg, input logic [WORD_W-1:0] x);
    return neg ? WORD_W'(-x) : x;
  endfunction

endpackage

// File: rtl/hilo_div_unit_if.sv
// EXE <-> divider handshake: operands in, stall/done and HI/LO result out.
interface hilo_div_if;
  import hilo_div_unit_pkg::*;

  logic               start;
  logic               signed_div;
  logic [WORD_W-1:0]  dividend;
  logic [WORD_W-1:0]  divisor;
  logic               cancel;
  logic               stall_req;
  logic               busy;
  logic               done;
  logic [DWORD_W-1:0] hilo;
  logic [1:0]         whilo;

  modport master (
    output start, signed_div, dividend, divisor, cancel,
    input  stall_req, busy, done, hilo, whilo
  );

  modport slave (
    input  start, signed_div, dividend, divisor, cancel,
    output stall_req, busy, done, hilo, whilo
  );
endinterface

// File: rtl/hilo_div_unit_div_step.sv
// One combinational restoring-division iteration on a 65-bit partial remainder.
module div_step
  import hilo_div_unit_pkg::*;
(
  input  logic [PR_W-1:0]   pr_i,
  input  logic [WORD_W-1:0] divisor_i,
  output logic [PR_W-1:0]   pr_o
);

  logic [WORD_W+1:0] hi_sh;
  logic [WORD_W+1:0] diff;
  logic [WORD_W+1:0] rem;
  logic              ge;

  // High half of the left-shifted remainder, trial-subtracted against divisor<<32.
  always_comb begin
    hi_sh = pr_i[PR_W-1:WORD_W-1];
    diff  = hi_sh - (WORD_W+2)'(divisor_i);
    ge    = (hi_sh >= (WORD_W+2)'(divisor_i));
    rem   = ge ? diff : hi_sh;
    pr_o  = PR_W'({rem, pr_i[WORD_W-2:0], ge});
  end

endmodule

// File: rtl/hilo_div_unit.sv
// Iterative 32-bit DIV/DIVU producing {remainder, quotient} on the HI/LO lanes.
module hilo_div_unit
  import hilo_div_unit_pkg::*;
#(
  parameter int unsigned ITER = DIV_ITER
) (
  input  logic     cpu_clk_50M,
  input  logic     cpu_rst_n,
  hilo_div_if.slave div_if
);

  localparam int unsigned CNT_W = $clog2(ITER);

  div_state_e         state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [PR_W-1:0]    pr_q;
  logic [PR_W-1:0]    pr_d;
  logic [WORD_W-1:0]  dvs_q;
  logic               neg_dvd_q;
  logic               neg_dvs_q;
  logic [DWORD_W-1:0] hilo_q;
  logic               done_q;
  logic               busy_q;
  logic [1:0]         whilo_q;

  logic               neg_dvd_in;
  logic               neg_dvs_in;
  logic [WORD_W-1:0]  quo_raw;
  logic [WORD_W-1:0]  rem_raw;
  logic [WORD_W-1:0]  quo_fix;
  logic [WORD_W-1:0]  rem_fix;

  div_step u_step (
    .pr_i      (pr_q),
    .divisor_i (dvs_q),
    .pr_o      (pr_d)
  );

  // Sign fix-up applied to the final iteration's output as it lands in hilo.
  always_comb begin
    neg_dvd_in = div_if.signed_div & div_if.dividend[WORD_W-1];
    neg_dvs_in = div_if.signed_div & div_if.divisor[WORD_W-1];
    quo_raw    = WORD_W'(pr_d);
    rem_raw    = WORD_W'(pr_d >> WORD_W);
    quo_fix    = (neg_dvd_q ^ neg_dvs_q) ? WORD_W'(-quo_raw) : quo_raw;
    rem_fix    = neg_dvd_q ? WORD_W'(-rem_raw) : rem_raw;
  end

  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state_q   <= DIV_IDLE;
      cnt_q     <= '0;
      pr_q      <= '0;
      dvs_q     <= '0;
      neg_dvd_q <= 1'b0;
      neg_dvs_q <= 1'b0;
      hilo_q    <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      whilo_q   <= WHILO_NONE;
    end else if (div_if.cancel) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      whilo_q <= WHILO_NONE;
    end else begin
      done_q  <= 1'b0;
      whilo_q <= WHILO_NONE;
      unique case (state_q)
        DIV_IDLE: begin
          if (div_if.start) begin
            busy_q <= 1'b1;
            if (div_if.divisor == '0) begin
              // Raw dividend parks in pr_q until DZERO publishes it as HI.
              state_q <= DIV_DZERO;
              pr_q    <= PR_W'(div_if.dividend);
            end else begin
              state_q   <= DIV_BUSY;
              cnt_q     <= '0;
              pr_q      <= PR_W'(abs_if(neg_dvd_in, div_if.dividend));
              dvs_q     <= abs_if(neg_dvs_in, div_if.divisor);
              neg_dvd_q <= neg_dvd_in;
              neg_dvs_q <= neg_dvs_in;
            end
          end
        end
        DIV_BUSY: begin
          pr_q  <= pr_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(ITER - 1)) begin
            state_q <= DIV_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            whilo_q <= WHILO_BOTH;
            hilo_q  <= {rem_fix, quo_fix};
          end
        end
        DIV_DZERO: begin
          state_q <= DIV_DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          whilo_q <= WHILO_BOTH;
          hilo_q  <= {pr_q[WORD_W-1:0], {WORD_W{1'b1}}};
        end
        DIV_DONE: state_q <= DIV_IDLE;
        default:  state_q <= DIV_IDLE;
      endcase
    end
  end

  assign div_if.stall_req = (div_if.start && (state_q == DIV_IDLE)) ||
                            (state_q == DIV_BUSY) || (state_q == DIV_DZERO);
  assign div_if.busy  = busy_q;
  assign div_if.done  = done_q;
  assign div_if.hilo  = hilo_q;
  assign div_if.whilo = whilo_q;

endmodule

// File: tb/tb_hilo_div_unit.sv
// Randomized and directed checks of hilo_div_unit against an arithmetic model.
module tb_hilo_div_unit;
  import hilo_div_unit_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hilo_div_if dif ();

  hilo_div_unit #(.ITER(DIV_ITER)) dut (
    .cpu_clk_50M (clk),
    .cpu_rst_n   (rst_n),
    .div_if      (dif)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [63:0] hilo_exp = 64'h0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: 64-bit signed arithmetic truncates toward zero, remainder takes dividend sign.
  function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] qv, rv;
    if (b == 32'h0) return {a, 32'hFFFF_FFFF};
    sa = sgn ? longint'($signed(a)) : longint'({32'h0, a});
    sb = sgn ? longint'($signed(b)) : longint'({32'h0, b});
    q  = sa / sb;
    r  = sa % sb;
    qv = q;
    rv = r;
    return {rv[31:0], qv[31:0]};
  endfunction

  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    int cyc;
    int stalls;
    bit seen;
    logic [63:0] exp;
    int unsigned lat;
    exp = ref_div(sgn, a, b);
    lat = (b == 32'h0) ? 2 : 33;
    @(negedge clk);
    dif.start = 1'b1; dif.signed_div = sgn; dif.dividend = a; dif.divisor = b;
    #1;
    stalls = int'(dif.stall_req);
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (dif.done) seen = 1'b1;
      else stalls += int'(dif.stall_req);
      if (cyc == 1) begin
        check_eq("busy_after_start", 64'(dif.busy), 64'h1);
        dif.start = 1'b0; dif.dividend = $urandom; dif.divisor = $urandom;
      end
    end
    check_eq("done_latency", 64'(cyc), 64'(lat));
    check_eq("stall_cycles", 64'(stalls), 64'(lat));
    check_eq("stall_in_done", 64'(dif.stall_req), 64'h0);
    check_eq("hilo", dif.hilo, exp);
    check_eq("whilo_done", 64'(dif.whilo), 64'(WHILO_BOTH));
    @(negedge clk);
    check_eq("done_pulse_end", 64'(dif.done), 64'h0);
    check_eq("whilo_after", 64'(dif.whilo), 64'h0);
    check_eq("hilo_hold", dif.hilo, exp);
    hilo_exp = exp;
  endtask

  initial begin
    logic [31:0] a, b;
    logic sgn;
    int unsigned sel;
    int done_seen;
    dif.start = 1'b0; dif.signed_div = 1'b0; dif.dividend = '0; dif.divisor = '0; dif.cancel = 1'b0;

    #12;
    check_eq("rst_hilo", dif.hilo, 64'h0);
    check_eq("rst_busy", 64'(dif.busy), 64'h0);
    check_eq("rst_done", 64'(dif.done), 64'h0);
    check_eq("rst_whilo", 64'(dif.whilo), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    run_div(1'b0, 32'd100, 32'd7);
    check_eq("divu_100_7", dif.hilo, {32'd2, 32'd14});
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2);
    check_eq("div_m7_2", dif.hilo, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_div(1'b1, 32'd7, 32'hFFFF_FFFE);
    check_eq("div_7_m2", dif.hilo, {32'h0000_0001, 32'hFFFF_FFFD});
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    check_eq("div_min_m1", dif.hilo, {32'h0, 32'h8000_0000});
    run_div(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    check_eq("divu_min_max", dif.hilo, {32'h8000_0000, 32'h0});
    run_div(1'b1, 32'h1234_5678, 32'h0);
    check_eq("div_zero", dif.hilo, {32'h1234_5678, 32'hFFFF_FFFF});

    // Cancel 10 cycles into BUSY: no done, hilo keeps the previous result.
    @(negedge clk);
    dif.start = 1'b1; dif.signed_div = 1'b0; dif.dividend = 32'hFFFF_FFFF; dif.divisor = 32'd3;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      dif.start = 1'b0;
    end
    dif.cancel = 1'b1;
    @(negedge clk);
    dif.cancel = 1'b0;
    check_eq("cancel_busy", 64'(dif.busy), 64'h0);
    check_eq("cancel_stall", 64'(dif.stall_req), 64'h0);
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      done_seen += int'(dif.done);
    end
    check_eq("cancel_no_done", 64'(done_seen), 64'h0);
    check_eq("cancel_hilo", dif.hilo, hilo_exp);
    run_div(1'b0, 32'd9, 32'd3);
    check_eq("divu_9_3", dif.hilo, {32'd0, 32'd3});

    // Cancel beats start in the same cycle.
    @(negedge clk);
    dif.start = 1'b1; dif.cancel = 1'b1; dif.dividend = 32'd5; dif.divisor = 32'd1;
    @(negedge clk);
    dif.start = 1'b0; dif.cancel = 1'b0;
    check_eq("cancel_prio_busy", 64'(dif.busy), 64'h0);

    // Asynchronous reset in the middle of BUSY.
    @(negedge clk);
    dif.start = 1'b1; dif.signed_div = 1'b1; dif.dividend = 32'hDEAD_BEEF; dif.divisor = 32'd77;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      dif.start = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_hilo", dif.hilo, 64'h0);
    check_eq("arst_busy", 64'(dif.busy), 64'h0);
    check_eq("arst_done", 64'(dif.done), 64'h0);
    check_eq("arst_whilo", 64'(dif.whilo), 64'h0);
    check_eq("arst_stall", 64'(dif.stall_req), 64'h0);
    hilo_exp = 64'h0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    run_div(1'b1, 32'hFFFF_FF00, 32'd10);

    for (int n = 0; n < 40; n++) begin
      sgn = 1'($urandom_range(0, 1));
      a   = $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      sel = $urandom_range(0, 7);
      case (sel)
        0:       b = 32'h0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'hFFFF_FFFF;
        3:       b = 32'($urandom_range(1, 65535));
        default: b = $urandom;
      endcase
      run_div(sgn, a, b);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
